// File: rtl/countdown_ctrl.sv
// Countdown timer control core: BCD MM:SS edit/run/pause/alarm sequencing.
// Optional macro CDC_ALARM_TIMEOUT_EN adds an automatic ALARM timeout after ALARM_SECS ticks.
module countdown_ctrl #(
    parameter int MAX_MIN    = 59,
    parameter int ALARM_SECS = 10
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       TICK,
    input  logic       KEY_SEL,
    input  logic       KEY_INC,
    input  logic       KEY_DEC,
    input  logic       KEY_START,
    output logic [3:0] MIN_T,
    output logic [3:0] MIN_O,
    output logic [3:0] SEC_T,
    output logic [3:0] SEC_O,
    output logic       EDIT_MIN,
    output logic       EDIT_SEC,
    output logic       RUNNING,
    output logic       ALARM
);

    localparam logic [7:0] MIN_TOP = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
    localparam logic [7:0] SEC_TOP = 8'h59;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET_MIN = 3'd1,
        ST_SET_SEC = 3'd2,
        ST_RUN     = 3'd3,
        ST_PAUSE   = 3'd4,
        ST_ALARM   = 3'd5
    } state_t;

    // Two-digit BCD increment, wrapping from top back to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        logic [7:0] r;
        if (v == top) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Two-digit BCD decrement, wrapping from 00 up to top.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = top;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    state_t     r_state;
    logic [7:0] r_min;
    logic [7:0] r_sec;
    logic [7:0] r_pre_min;
    logic [7:0] r_pre_sec;
    logic       r_edit_min;
    logic       r_edit_sec;
    logic       r_running;
    logic       r_alarm;

    state_t     w_state_nxt;
    logic [7:0] w_min_nxt;
    logic [7:0] w_sec_nxt;
    logic [7:0] w_pre_min_nxt;
    logic [7:0] w_pre_sec_nxt;

    // One key acts per cycle: START > SEL > INC > DEC.
    logic w_start, w_sel, w_inc, w_dec, w_any_key, w_time_zero;
    assign w_start     = KEY_START;
    assign w_sel       = KEY_SEL & ~KEY_START;
    assign w_inc       = KEY_INC & ~KEY_SEL & ~KEY_START;
    assign w_dec       = KEY_DEC & ~KEY_INC & ~KEY_SEL & ~KEY_START;
    assign w_any_key   = KEY_SEL | KEY_INC | KEY_DEC | KEY_START;
    assign w_time_zero = (r_min == 8'h00) && (r_sec == 8'h00);

`ifdef CDC_ALARM_TIMEOUT_EN
    localparam int ACNT_W = (ALARM_SECS > 1) ? $clog2(ALARM_SECS + 1) : 1;
    logic [ACNT_W-1:0] r_acnt;
    logic [ACNT_W-1:0] w_acnt_nxt;
`endif

    // Next-state, next-time and preset computation.
    always_comb begin
        w_state_nxt   = r_state;
        w_min_nxt     = r_min;
        w_sec_nxt     = r_sec;
        w_pre_min_nxt = r_pre_min;
        w_pre_sec_nxt = r_pre_sec;
`ifdef CDC_ALARM_TIMEOUT_EN
        w_acnt_nxt    = r_acnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (!w_time_zero) begin
                        w_state_nxt   = ST_RUN;
                        w_pre_min_nxt = r_min;
                        w_pre_sec_nxt = r_sec;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_sel) begin
                    w_state_nxt = ST_SET_MIN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SET_MIN, ST_SET_SEC: begin
                if (w_start) begin
                    if (!w_time_zero) begin
                        w_state_nxt   = ST_RUN;
                        w_pre_min_nxt = r_min;
                        w_pre_sec_nxt = r_sec;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_sel) begin
                    w_state_nxt = (r_state == ST_SET_MIN) ? ST_SET_SEC : ST_IDLE;
                end else if (w_inc) begin
                    if (r_state == ST_SET_MIN) begin
                        w_min_nxt = bcd_inc(r_min, MIN_TOP);
                    end else begin
                        w_sec_nxt = bcd_inc(r_sec, SEC_TOP);
                    end
                end else if (w_dec) begin
                    if (r_state == ST_SET_MIN) begin
                        w_min_nxt = bcd_dec(r_min, MIN_TOP);
                    end else begin
                        w_sec_nxt = bcd_dec(r_sec, SEC_TOP);
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RUN: begin
                if (w_start) begin
                    w_state_nxt = ST_PAUSE;
                end else if (TICK) begin
                    if (r_sec != 8'h00) begin
                        w_sec_nxt = bcd_dec(r_sec, SEC_TOP);
                    end else if (r_min != 8'h00) begin
                        w_min_nxt = bcd_dec(r_min, MIN_TOP);
                        w_sec_nxt = SEC_TOP;
                    end else begin
                        w_sec_nxt = r_sec;
                    end
                    // Reaching 00:00 enters ALARM on this same edge.
                    if ((w_min_nxt == 8'h00) && (w_sec_nxt == 8'h00)) begin
                        w_state_nxt = ST_ALARM;
`ifdef CDC_ALARM_TIMEOUT_EN
                        w_acnt_nxt  = '0;
`endif
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (w_start) begin
                    w_state_nxt = ST_RUN;
                end else if (w_sel) begin
                    w_state_nxt = ST_IDLE;
                    w_min_nxt   = r_pre_min;
                    w_sec_nxt   = r_pre_sec;
                end else begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_ALARM: begin
                if (w_any_key) begin
                    w_state_nxt = ST_IDLE;
                    w_min_nxt   = r_pre_min;
                    w_sec_nxt   = r_pre_sec;
`ifdef CDC_ALARM_TIMEOUT_EN
                end else if (TICK) begin
                    if (r_acnt == ACNT_W'(ALARM_SECS - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_min_nxt   = r_pre_min;
                        w_sec_nxt   = r_pre_sec;
                    end else begin
                        w_acnt_nxt  = r_acnt + ACNT_W'(1);
                    end
`endif
                end else begin
                    w_state_nxt = ST_ALARM;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, time, preset and registered flag outputs.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state    <= ST_IDLE;
            r_min      <= 8'h00;
            r_sec      <= 8'h00;
            r_pre_min  <= 8'h00;
            r_pre_sec  <= 8'h00;
            r_edit_min <= 1'b0;
            r_edit_sec <= 1'b0;
            r_running  <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_min      <= w_min_nxt;
            r_sec      <= w_sec_nxt;
            r_pre_min  <= w_pre_min_nxt;
            r_pre_sec  <= w_pre_sec_nxt;
            r_edit_min <= (w_state_nxt == ST_SET_MIN);
            r_edit_sec <= (w_state_nxt == ST_SET_SEC);
            r_running  <= (w_state_nxt == ST_RUN);
            r_alarm    <= (w_state_nxt == ST_ALARM);
        end
    end

`ifdef CDC_ALARM_TIMEOUT_EN
    // Alarm duration counter.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_acnt <= '0;
        end else begin
            r_acnt <= w_acnt_nxt;
        end
    end
`endif

    assign MIN_T    = r_min[7:4];
    assign MIN_O    = r_min[3:0];
    assign SEC_T    = r_sec[7:4];
    assign SEC_O    = r_sec[3:0];
    assign EDIT_MIN = r_edit_min;
    assign EDIT_SEC = r_edit_sec;
    assign RUNNING  = r_running;
    assign ALARM    = r_alarm;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: directed scenarios plus random key/tick traffic,
// every cycle compared against a seconds-based behavioural model.
module tb_countdown_ctrl;

    localparam int MAX_MIN    = 59;
    localparam int ALARM_SECS = 10;

    localparam int M_IDLE = 0, M_SETMIN = 1, M_SETSEC = 2, M_RUN = 3, M_PAUSE = 4, M_ALARM = 5;
    localparam int K_SEL = 0, K_INC = 1, K_DEC = 2, K_START = 3, K_TICK = 4, K_CLR = 5;

    logic CLK = 1'b0;
    logic CLR = 1'b0, TICK = 1'b0;
    logic KEY_SEL = 1'b0, KEY_INC = 1'b0, KEY_DEC = 1'b0, KEY_START = 1'b0;
    logic [3:0] MIN_T, MIN_O, SEC_T, SEC_O;
    logic EDIT_MIN, EDIT_SEC, RUNNING, ALARM;

    int errors = 0;
    int checks = 0;

    // Model state: mode plus time and preset as total seconds.
    int m_mode = M_IDLE;
    int m_time = 0;
    int m_pre  = 0;
    int m_acnt = 0;

    countdown_ctrl #(.MAX_MIN(MAX_MIN), .ALARM_SECS(ALARM_SECS)) dut (
        .CLK(CLK), .CLR(CLR), .TICK(TICK),
        .KEY_SEL(KEY_SEL), .KEY_INC(KEY_INC), .KEY_DEC(KEY_DEC), .KEY_START(KEY_START),
        .MIN_T(MIN_T), .MIN_O(MIN_O), .SEC_T(SEC_T), .SEC_O(SEC_O),
        .EDIT_MIN(EDIT_MIN), .EDIT_SEC(EDIT_SEC), .RUNNING(RUNNING), .ALARM(ALARM)
    );

    always #5 CLK = ~CLK;

    task automatic model_step(input bit clr, input bit sel, input bit inc, input bit dec,
                              input bit start, input bit tick);
        int mm, ss;
        mm = m_time / 60;
        ss = m_time % 60;
        if (clr) begin
            m_mode = M_IDLE; m_time = 0; m_pre = 0; m_acnt = 0;
        end else if (m_mode == M_IDLE) begin
            if (start) begin
                if (m_time != 0) begin m_pre = m_time; m_mode = M_RUN; end
            end else if (sel) m_mode = M_SETMIN;
        end else if (m_mode == M_SETMIN || m_mode == M_SETSEC) begin
            if (start) begin
                if (m_time != 0) begin m_pre = m_time; m_mode = M_RUN; end
                else m_mode = M_IDLE;
            end else if (sel) begin
                m_mode = (m_mode == M_SETMIN) ? M_SETSEC : M_IDLE;
            end else if (inc || dec) begin
                if (m_mode == M_SETMIN) begin
                    if (inc) mm = (mm == MAX_MIN) ? 0 : mm + 1;
                    else     mm = (mm == 0) ? MAX_MIN : mm - 1;
                end else begin
                    if (inc) ss = (ss == 59) ? 0 : ss + 1;
                    else     ss = (ss == 0) ? 59 : ss - 1;
                end
                m_time = mm * 60 + ss;
            end
        end else if (m_mode == M_RUN) begin
            if (start) m_mode = M_PAUSE;
            else if (tick) begin
                if (m_time > 0) m_time = m_time - 1;
                if (m_time == 0) begin m_mode = M_ALARM; m_acnt = 0; end
            end
        end else if (m_mode == M_PAUSE) begin
            if (start) m_mode = M_RUN;
            else if (sel) begin m_mode = M_IDLE; m_time = m_pre; end
        end else begin
            if (sel || inc || dec || start) begin
                m_mode = M_IDLE; m_time = m_pre;
            end
`ifdef CDC_ALARM_TIMEOUT_EN
            else if (tick) begin
                m_acnt = m_acnt + 1;
                if (m_acnt == ALARM_SECS) begin m_mode = M_IDLE; m_time = m_pre; end
            end
`endif
        end
    endtask

    function automatic logic [15:0] exp_digits();
        int mm, ss;
        mm = m_time / 60;
        ss = m_time % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [3:0] exp_flags();
        return {m_mode == M_SETMIN, m_mode == M_SETSEC, m_mode == M_RUN, m_mode == M_ALARM};
    endfunction

    task automatic check_model();
        logic [15:0] d;
        logic [3:0]  f;
        d = {MIN_T, MIN_O, SEC_T, SEC_O};
        f = {EDIT_MIN, EDIT_SEC, RUNNING, ALARM};
        checks++;
        assert (d === exp_digits()) else begin
            errors++;
            $error("FAIL time: got %h expected %h", d, exp_digits());
        end
        checks++;
        assert (f === exp_flags()) else begin
            errors++;
            $error("FAIL flags(em,es,run,al): got %b expected %b", f, exp_flags());
        end
    endtask

    task automatic check_const(input string tag, input logic [15:0] ed, input logic [3:0] ef);
        logic [19:0] obs;
        obs = {MIN_T, MIN_O, SEC_T, SEC_O, EDIT_MIN, EDIT_SEC, RUNNING, ALARM};
        checks++;
        assert (obs === {ed, ef}) else begin
            errors++;
            $error("FAIL %s: got time=%h flags=%b expected time=%h flags=%b",
                   tag, obs[19:4], obs[3:0], ed, ef);
        end
    endtask

    task automatic step(input bit clr, input bit sel, input bit inc, input bit dec,
                        input bit start, input bit tick);
        @(negedge CLK);
        CLR = clr; KEY_SEL = sel; KEY_INC = inc; KEY_DEC = dec; KEY_START = start; TICK = tick;
        @(posedge CLK);
        model_step(clr, sel, inc, dec, start, tick);
        #1;
        check_model();
    endtask

    task automatic key(input int k, input int n = 1);
        for (int i = 0; i < n; i++)
            step(k == K_CLR, k == K_SEL, k == K_INC, k == K_DEC, k == K_START, k == K_TICK);
    endtask

    initial begin
        // Reset and edit
        key(K_CLR);
        check_const("reset", 16'h0000, 4'b0000);
        key(K_SEL); key(K_INC, 3); key(K_SEL); key(K_DEC, 2);
        check_const("edit", 16'h0358, 4'b0100);
        key(K_SEL);
        check_const("edit_exit", 16'h0358, 4'b0000);

        // Minute wrap
        key(K_CLR); key(K_SEL); key(K_DEC);
        check_const("min_wrap_dn", 16'h5900, 4'b1000);
        key(K_INC);
        check_const("min_wrap_up", 16'h0000, 4'b1000);

        // Countdown from 01:00
        key(K_INC); key(K_SEL); key(K_SEL); key(K_START);
        check_const("start", 16'h0100, 4'b0010);
        key(K_TICK);
        check_const("first_tick", 16'h0059, 4'b0010);
        key(K_TICK, 58);
        check_const("last_sec", 16'h0001, 4'b0010);
        key(K_TICK);
        check_const("alarm", 16'h0000, 4'b0001);

        // Pause, START/TICK priority, cancel
        key(K_INC);
        check_const("alarm_exit", 16'h0100, 4'b0000);
        key(K_START); key(K_TICK, 30);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_const("pause", 16'h0030, 4'b0000);
        key(K_TICK, 3);
        check_const("pause_hold", 16'h0030, 4'b0000);
        key(K_SEL);
        check_const("cancel", 16'h0100, 4'b0000);

        // Zero start and mid-run reset
        key(K_CLR); key(K_START);
        check_const("zero_start", 16'h0000, 4'b0000);
        key(K_SEL); key(K_SEL); key(K_INC, 10); key(K_START);
        check_const("run_10", 16'h0010, 4'b0010);
        key(K_CLR);
        check_const("mid_run_clr", 16'h0000, 4'b0000);

        // Alarm exit by key, then by timeout (if built)
        key(K_SEL); key(K_SEL); key(K_INC, 5); key(K_START); key(K_TICK, 5);
        check_const("alarm_05", 16'h0000, 4'b0001);
        key(K_INC);
        check_const("alarm_key_exit", 16'h0005, 4'b0000);
        key(K_START); key(K_TICK, 5); key(K_TICK, 9);
        check_const("alarm_9_ticks", 16'h0000, 4'b0001);
        key(K_TICK);
`ifdef CDC_ALARM_TIMEOUT_EN
        check_const("alarm_timeout", 16'h0005, 4'b0000);
`else
        check_const("alarm_persist", 16'h0000, 4'b0001);
`endif

        // Random traffic, including simultaneous keys
        key(K_CLR);
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 12,
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 40);
        end

        @(negedge CLK);
        CLR = 1'b0; KEY_SEL = 1'b0; KEY_INC = 1'b0; KEY_DEC = 1'b0; KEY_START = 1'b0; TICK = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
